// File: rtl/ahb_master_pkg.sv
// Shared constants, state encoding and command legality check
// for the single-transfer AHB-lite master.
package ahb_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    ERR
  } state_e;

  function automatic logic cmd_legal(
    input logic [1:0] size,
    input logic [1:0] alo
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      ({1'b0, size} == HSIZE_BYTE): ok = 1'b1;
      ({1'b0, size} == HSIZE_HALF): ok = ~alo[0];
      ({1'b0, size} == HSIZE_WORD): ok = (alo == 2'b00);
      default:                      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Clearable up-counter that wraps at rollover_val back to 1 and
// flags (registered) the cycle in which it holds rollover_val.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] cnt_q, cnt_d;
  logic                    flag_q, flag_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (count_enable)
      cnt_d = (cnt_q == rollover_val) ? NUM_CNT_BITS'(1)
                                      : cnt_q + 1'b1;
    flag_d = ~clear && (cnt_d == rollover_val);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign count_out     = cnt_q;
  assign rollover_flag = flag_q;

endmodule

// File: rtl/ahb_lite_master.sv
// Single-transfer AHB-lite initiator with req/busy/done handshake.
// Define AHB_MASTER_TIMEOUT_EN to abort data phases stuck in wait.
module ahb_lite_master
  import ahb_master_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [31:0]       hwdata,
  input  logic [31:0]       hrdata,
  input  logic              hready,
  input  logic              hresp
);

  state_e            state_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic [ADDR_W-1:0] haddr_q;
  logic [1:0]        htrans_q;
  logic              hwrite_q;
  logic [2:0]        hsize_q;
  logic [31:0]       hwdata_q;
  logic              tmo;

`ifdef AHB_MASTER_TIMEOUT_EN
  logic [3:0] wait_cnt;
  logic       tmo_flag;

  flex_counter #(
    .NUM_CNT_BITS(4)
  ) u_tmo (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (state_q == ADDR),
    .count_enable ((state_q == DATA || state_q == ERR) && !hready),
    .rollover_val (4'(TIMEOUT_CYC)),
    .count_out    (wait_cnt),
    .rollover_flag(tmo_flag)
  );

  assign tmo = tmo_flag && (wait_cnt != 4'd0);
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      haddr_q  <= '0;
      htrans_q <= HTRANS_IDLE;
      hwrite_q <= 1'b0;
      hsize_q  <= '0;
      hwdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            if (cmd_legal(req_size, req_addr[1:0])) begin
              state_q  <= ADDR;
              busy_q   <= 1'b1;
              htrans_q <= HTRANS_NONSEQ;
              haddr_q  <= req_addr;
              hwrite_q <= req_write;
              hsize_q  <= {1'b0, req_size};
              if (req_write)
                hwdata_q <= req_wdata;
            end else begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end
          end
        end
        ADDR: begin
          htrans_q <= HTRANS_IDLE;
          state_q  <= DATA;
        end
        DATA: begin
          if (tmo || (hresp && hready)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else if (hresp) begin
            state_q <= ERR;
          end else if (hready) begin
            if (!hwrite_q)
              rdata_q <= hrdata;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ERR: begin
          // hresp low here is a slave violation; still an error
          if (tmo || hready) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign rdata  = rdata_q;
  assign haddr  = haddr_q;
  assign htrans = htrans_q;
  assign hwrite = hwrite_q;
  assign hsize  = hsize_q;
  assign hwdata = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: vector table, scripted slave,
// scoreboard queue of expected completions.
module tb_ahb_lite_master;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        req;
  logic        req_write;
  logic [15:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [15:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  ahb_lite_master #(
    .ADDR_W     (16),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .req      (req),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_size (req_size),
    .req_wdata(req_wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .haddr    (haddr),
    .htrans   (htrans),
    .hwrite   (hwrite),
    .hsize    (hsize),
    .hwdata   (hwdata),
    .hrdata   (hrdata),
    .hready   (hready),
    .hresp    (hresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] hrd;
    int          nwait;
    logic        eresp;
    logic        pulse;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_rdata = '0;
  vec_t        tbl[9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_xfer(input vec_t v);
    exp_t e;
    exp_t x;
    bit   act;
    bit   got;
    int   k;
    int   nons;
    @(negedge clk);
    req       = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_size  = v.size;
    req_wdata = v.wdata;
    hready    = 1'b1;
    hresp     = 1'b0;
    if (!v.exp_err && !v.wr)
      model_rdata = v.hrd;
    e.err   = v.exp_err;
    e.rdata = model_rdata;
    e.lat   = v.exp_lat;
    sbq.push_back(e);
    act  = 0;
    got  = 0;
    k    = 0;
    nons = 0;
    for (int c = 1; c <= 60 && !got; c++) begin
      @(negedge clk);
      req = v.pulse && (c == 2);
      if (done) begin
        x = sbq.pop_front();
        chk("done_lat", c, x.lat);
        chk("err", {31'd0, err}, {31'd0, x.err});
        chk("rdata", rdata, x.rdata);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        got = 1;
      end else begin
        if (act) begin
          hrdata = (k >= v.nwait) ? v.hrd : ~v.hrd;
          if (k < v.nwait) begin
            hready = 1'b0;
            hresp  = 1'b0;
          end else if (v.eresp) begin
            hready = (k != v.nwait);
            hresp  = 1'b1;
          end else begin
            hready = 1'b1;
            hresp  = 1'b0;
          end
          if (k == 0 && v.wr)
            chk("hwdata", hwdata, v.wdata);
          if (k == 0)
            chk("htrans_data", {30'd0, htrans}, 32'd0);
          k++;
        end
        if (htrans == 2'b10) begin
          nons++;
          chk("haddr", {16'd0, haddr}, {16'd0, v.addr});
          chk("hwrite", {31'd0, hwrite}, {31'd0, v.wr});
          chk("hsize", {29'd0, hsize}, {30'd0, v.size});
          chk("busy_addr", {31'd0, busy}, 32'd1);
          act = 1;
          k   = 0;
        end
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got none want done");
      void'(sbq.pop_front());
    end
    chk("nonseq_cnt", nons, (v.exp_lat == 1) ? 0 : 1);
    req    = 1'b0;
    hready = 1'b1;
    hresp  = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("idle_htrans", {30'd0, htrans}, 32'd0);
      chk("idle_done", {31'd0, done}, 32'd0);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_done"}, {31'd0, done}, 32'd0);
    chk({nm, "_err"}, {31'd0, err}, 32'd0);
    chk({nm, "_rdata"}, rdata, 32'd0);
    chk({nm, "_haddr"}, {16'd0, haddr}, 32'd0);
    chk({nm, "_htrans"}, {30'd0, htrans}, 32'd0);
    chk({nm, "_hwrite"}, {31'd0, hwrite}, 32'd0);
    chk({nm, "_hsize"}, {29'd0, hsize}, 32'd0);
    chk({nm, "_hwdata"}, hwdata, 32'd0);
  endtask

  initial begin
    vec_t tv;
    //          wr    addr      sz    wdata         hrd
    //          nwait eresp pulse exp_err lat
    tbl[0] = '{1'b1, 16'h0004, 2'd2, 32'hDEADBEEF, 32'h0,
               0, 1'b0, 1'b0, 1'b0, 3};
    tbl[1] = '{1'b0, 16'h0010, 2'd2, 32'h0, 32'h12345678,
               2, 1'b0, 1'b1, 1'b0, 5};
    tbl[2] = '{1'b0, 16'h0020, 2'd2, 32'h0, 32'hCAFEF00D,
               1, 1'b1, 1'b0, 1'b1, 5};
    tbl[3] = '{1'b0, 16'h0003, 2'd1, 32'h0, 32'h0,
               0, 1'b0, 1'b0, 1'b1, 1};
    tbl[4] = '{1'b1, 16'h0000, 2'd3, 32'h1, 32'h0,
               0, 1'b0, 1'b0, 1'b1, 1};
    tbl[5] = '{1'b0, 16'h0002, 2'd2, 32'h0, 32'h0,
               0, 1'b0, 1'b0, 1'b1, 1};
    tbl[6] = '{1'b0, 16'h0007, 2'd0, 32'h0, 32'hA5A50001,
               0, 1'b0, 1'b0, 1'b0, 3};
    tbl[7] = '{1'b1, 16'h0006, 2'd1, 32'h0000BEEF, 32'h0,
               3, 1'b0, 1'b0, 1'b0, 6};
    tbl[8] = '{1'b1, 16'h0100, 2'd2, 32'h55AA55AA, 32'h0,
               0, 1'b1, 1'b0, 1'b1, 4};

    n_rst     = 1'b0;
    req       = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_size  = '0;
    req_wdata = '0;
    hrdata    = '0;
    hready    = 1'b1;
    hresp     = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    n_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_htrans0", {30'd0, htrans}, 32'd0);
      chk("idle_done0", {31'd0, done}, 32'd0);
      chk("idle_busy0", {31'd0, busy}, 32'd0);
    end

    for (int i = 0; i < 9; i++)
      do_xfer(tbl[i]);

    // reset asserted while the slave is inserting wait states
    @(negedge clk);
    req       = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0040;
    req_size  = 2'd2;
    hready    = 1'b0;
    @(negedge clk);
    req = 1'b0;
    chk("mid_nonseq", {30'd0, htrans}, 32'h2);
    repeat (2) @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    n_rst = 1'b0;
    #1;
    chk_reset_vals("midrst");
    model_rdata = '0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_nodone", {31'd0, done}, 32'd0);
    end
    n_rst  = 1'b1;
    hready = 1'b1;
    tv = '{1'b0, 16'h0044, 2'd2, 32'h0, 32'h0BADF00D,
           1, 1'b0, 1'b0, 1'b0, 4};
    do_xfer(tv);

`ifdef AHB_MASTER_TIMEOUT_EN
    tv = '{1'b0, 16'h0048, 2'd2, 32'h0, 32'h11112222,
           1000, 1'b0, 1'b0, 1'b1, 3 + TMO};
    do_xfer(tv);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
